// File: rtl/npu_bus_bridge.sv
// Bus-slave bridge from the NPU system bus to the four local SRAM buffers (act, wgt, out, bias).
// Optional: define NPU_BRIDGE_WR_PROTECT_EN to answer writes to the output region with ERROR.
module npu_bus_bridge #(
  parameter int unsigned DWidth    = 32,
  parameter int unsigned AWidth    = 12,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ACT_BASE  = 'h000,
  parameter int unsigned WGT_BASE  = 'h400,
  parameter int unsigned OUT_BASE  = 'h800,
  parameter int unsigned BIAS_BASE = 'hB00
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sel_i,
  input  logic                trans_i,
  input  logic                ready_i,
  input  logic                write_i,
  input  logic [AWidth-1:0]   addr_i,
  input  logic [DWidth-1:0]   wdata_i,
  output logic [3:0]          buf_wen_o,
  output logic [3:0]          buf_ren_o,
  output logic [AWidth-1:0]   buf_addr_o,
  output logic [DWidth-1:0]   buf_wdata_o,
  input  logic [4*DWidth-1:0] buf_rdata_i,
  output logic [DWidth-1:0]   rdata_o,
  output logic                resp_o,
  output logic                ready_o
);

  localparam int unsigned ActSize  = 'h400;
  localparam int unsigned WgtSize  = 'h400;
  localparam int unsigned OutSize  = 'h300;
  localparam int unsigned BiasSize = 'h100;
  localparam int unsigned MapTop   = 'hC00;

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StRwait,
    StDone,
    StErr1,
    StErr2
  } state_e;

  state_e              state_q, state_d;
  logic                write_q;
  logic [1:0]          region_q;
  logic [AWidth-1:0]   offset_q;
  logic [DWidth-1:0]   wdata_q;
  logic [DWidth-1:0]   rdata_q;
  logic [2:0]          cnt_q;

  logic [31:0]         addr_ext;
  logic                hit;
  logic                wp_err;
  logic                accept;
  logic [1:0]          dec_region;
  logic [AWidth-1:0]   dec_offset;
  logic [DWidth-1:0]   rd_slice;

  assign addr_ext = 32'(addr_i);

  // Unsigned wrap makes (addr - base) < size a half-open [base, base+size) test.
  always_comb begin
    hit        = addr_ext < MapTop;
    dec_region = 2'd0;
    dec_offset = '0;
    if ((addr_ext - ACT_BASE) < ActSize) begin
      dec_region = 2'd0;
      dec_offset = AWidth'(addr_ext - ACT_BASE);
    end else if ((addr_ext - WGT_BASE) < WgtSize) begin
      dec_region = 2'd1;
      dec_offset = AWidth'(addr_ext - WGT_BASE);
    end else if ((addr_ext - OUT_BASE) < OutSize) begin
      dec_region = 2'd2;
      dec_offset = AWidth'(addr_ext - OUT_BASE);
    end else if ((addr_ext - BIAS_BASE) < BiasSize) begin
      dec_region = 2'd3;
      dec_offset = AWidth'(addr_ext - BIAS_BASE);
    end else begin
      hit = 1'b0;
    end
  end

`ifdef NPU_BRIDGE_WR_PROTECT_EN
  assign wp_err = write_i && (dec_region == 2'd2);
`else
  assign wp_err = 1'b0;
`endif

  assign ready_o = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);
  assign resp_o  = (state_q == StErr1) || (state_q == StErr2);
  assign accept  = (state_q == StIdle) && sel_i && trans_i && ready_i && ready_o;

  assign buf_addr_o  = offset_q;
  assign buf_wdata_o = wdata_q;
  assign rdata_o     = rdata_q;

  always_comb begin
    unique case (region_q)
      2'd0:    rd_slice = buf_rdata_i[0*DWidth +: DWidth];
      2'd1:    rd_slice = buf_rdata_i[1*DWidth +: DWidth];
      2'd2:    rd_slice = buf_rdata_i[2*DWidth +: DWidth];
      default: rd_slice = buf_rdata_i[3*DWidth +: DWidth];
    endcase
  end

  always_comb begin
    buf_wen_o = '0;
    buf_ren_o = '0;
    if (state_q == StAccess) begin
      if (write_q) buf_wen_o = 4'b0001 << region_q;
      else         buf_ren_o = 4'b0001 << region_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = (hit && !wp_err) ? StAccess : StErr1;
      end
      StAccess: state_d = write_q ? StDone : StRwait;
      StRwait:  if (cnt_q == 3'd0) state_d = StDone;
      StDone:   state_d = StIdle;
      StErr1:   state_d = StErr2;
      StErr2:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Offset and write data only move on a mapped accept so they hold while strobes are low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_q  <= 1'b0;
      region_q <= 2'd0;
      offset_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= 3'd0;
    end else begin
      if (accept && hit && !wp_err) begin
        write_q  <= write_i;
        region_q <= dec_region;
        offset_q <= dec_offset;
        wdata_q  <= wdata_i;
      end
      if (state_q == StAccess) begin
        cnt_q <= 3'(RD_LAT - 1);
      end else if ((state_q == StRwait) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if ((state_q == StRwait) && (cnt_q == 3'd0)) begin
        rdata_q <= rd_slice;
      end else if (state_q == StErr1) begin
        rdata_q <= '0;
      end
    end
  end

endmodule
